// File: rtl/adc_cal_pkg.sv
// Shared types for the ADC sampling-phase calibration path.
// Latency: n/a. Backpressure: n/a.
package adc_cal_pkg;

    localparam int CAL_ADC_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT,
        ST_DONE
    } sweep_state_t;

    typedef logic signed [CAL_ADC_W:0] margin_t;

    localparam margin_t MARGIN_NONE = margin_t'(-(2 ** CAL_ADC_W));

endpackage

// File: rtl/adc_phase_sweep_if.sv
// Per-phase result port: valid/ready, payload is phase, margin and eye-open flag.
// Latency: n/a. Backpressure: payload held by the source until valid & ready.
interface adc_phase_sweep_if #(
    parameter int ADC_W   = 6,
    parameter int PHASE_W = 5
);
    logic                     res_valid;
    logic                     res_ready;
    logic [PHASE_W-1:0]       res_phase;
    logic signed [ADC_W:0]    res_margin;
    logic                     res_open;

    modport master (output res_valid, res_phase, res_margin, res_open, input res_ready);
    modport slave  (input res_valid, res_phase, res_margin, res_open, output res_ready);
endinterface

// File: rtl/ref_delay_line.sv
// Aligns the transmitted PRBS bit with the ADC capture path.
// Latency: REF_LAT cycles (wire when 0). Backpressure: none, free-running.
module ref_delay_line #(
    parameter int REF_LAT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    generate
        if (REF_LAT == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout           = din;
        end else begin : g_shift
            logic [REF_LAT-1:0] sr_q;
            logic [REF_LAT-1:0] sr_d;

            always_comb begin
                sr_d    = sr_q << 1;
                sr_d[0] = din;
            end

            always_ff @(posedge clk) begin
                if (rst) sr_q <= '0;
                else     sr_q <= sr_d;
            end

            assign dout = sr_q[REF_LAT-1];
        end
    endgenerate
endmodule

// File: rtl/adc_phase_sweep.sv
// Sweeps the ADC clock phase, measures the vertical eye per phase, keeps the best phase.
// Latency: SETTLE + 2^LOG2_NSAMP + 1 cycles to each result. Backpressure: sweep stalls in REPORT until res_ready.
module adc_phase_sweep
    import adc_cal_pkg::*;
#(
    parameter int ADC_W      = 6,
    parameter int PHASE_W    = 5,
    parameter int N_PHASE    = 20,
    parameter int SETTLE     = 16,
    parameter int LOG2_NSAMP = 10,
    parameter int REF_LAT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADC_W-1:0]      adc_data,
    input  logic                  prbs_bit,
    output logic [PHASE_W-1:0]    phase_code,
    output logic                  busy,
    output logic                  done,
    adc_phase_sweep_if.master     res,
    output logic [PHASE_W-1:0]    best_phase,
    output logic signed [ADC_W:0] best_margin
);
    localparam int SET_W = $clog2(SETTLE) + 1;
    localparam int SMP_W = LOG2_NSAMP + 1;
    localparam logic [SMP_W-1:0]      NSAMP      = SMP_W'(2 ** LOG2_NSAMP);
    localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(N_PHASE - 1);
    localparam logic signed [ADC_W:0] M_NONE     = {1'b1, {ADC_W{1'b0}}};

    sweep_state_t          state_q, state_d;
    logic [SET_W-1:0]      set_cnt_q, set_cnt_d;
    logic [SMP_W-1:0]      smp_cnt_q, smp_cnt_d;
    logic [ADC_W-1:0]      min_hi_q, min_hi_d, max_lo_q, max_lo_d;
    logic                  seen_hi_q, seen_hi_d, seen_lo_q, seen_lo_d;
    logic [PHASE_W-1:0]    phase_q, phase_d, rphase_q, rphase_d;
    logic [PHASE_W-1:0]    best_phase_q, best_phase_d, shd_phase_q, shd_phase_d;
    logic signed [ADC_W:0] rmargin_q, rmargin_d, best_margin_q, best_margin_d;
    logic signed [ADC_W:0] shd_margin_q, shd_margin_d;
    logic                  vld_q, vld_d, ropen_q, ropen_d;
    logic                  done_q, done_d, busy_q, busy_d;
    logic                  ref_bit;
    logic signed [ADC_W:0] meas_margin;

    ref_delay_line #(.REF_LAT(REF_LAT)) u_ref (
        .clk  (clk),
        .rst  (rst),
        .din  (prbs_bit),
        .dout (ref_bit)
    );

    // A missing symbol class makes the eye unmeasurable, so it reports as the worst margin.
    always_comb begin
        meas_margin = $signed({1'b0, min_hi_q}) - $signed({1'b0, max_lo_q});
        if (!(seen_hi_q && seen_lo_q)) meas_margin = M_NONE;
    end

    always_comb begin
        state_d       = state_q;
        set_cnt_d     = set_cnt_q;
        smp_cnt_d     = smp_cnt_q;
        min_hi_d      = min_hi_q;
        max_lo_d      = max_lo_q;
        seen_hi_d     = seen_hi_q;
        seen_lo_d     = seen_lo_q;
        phase_d       = phase_q;
        rphase_d      = rphase_q;
        rmargin_d     = rmargin_q;
        ropen_d       = ropen_q;
        vld_d         = vld_q;
        done_d        = 1'b0;
        best_phase_d  = best_phase_q;
        best_margin_d = best_margin_q;
        shd_phase_d   = shd_phase_q;
        shd_margin_d  = shd_margin_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_SETTLE;
                    phase_d       = '0;
                    best_phase_d  = '0;
                    best_margin_d = M_NONE;
                    set_cnt_d     = SET_W'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (set_cnt_q == '0) begin
                    state_d   = ST_MEASURE;
                    min_hi_d  = '1;
                    max_lo_d  = '0;
                    seen_hi_d = 1'b0;
                    seen_lo_d = 1'b0;
                    smp_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt_q - 1'b1;
                end
            end
            ST_MEASURE: begin
                if (smp_cnt_q == NSAMP) begin
                    state_d   = ST_REPORT;
                    vld_d     = 1'b1;
                    rphase_d  = phase_q;
                    rmargin_d = meas_margin;
                    ropen_d   = seen_hi_q && seen_lo_q && !meas_margin[ADC_W] && (meas_margin != '0);
                end else begin
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (ref_bit) begin
                        seen_hi_d = 1'b1;
                        if (adc_data < min_hi_q) min_hi_d = adc_data;
                    end else begin
                        seen_lo_d = 1'b1;
                        if (adc_data > max_lo_q) max_lo_d = adc_data;
                    end
                end
            end
            ST_REPORT: begin
                if (vld_q && res.res_ready) begin
                    vld_d = 1'b0;
                    // Strict compare: on a tie the earlier (lower) phase is kept.
                    if (rmargin_q > best_margin_q) begin
                        best_phase_d  = rphase_q;
                        best_margin_d = rmargin_q;
                    end
                    if (phase_q == LAST_PHASE) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        phase_d      = best_phase_d;
                        shd_phase_d  = best_phase_d;
                        shd_margin_d = best_margin_d;
                    end else begin
                        state_d   = ST_SETTLE;
                        phase_d   = phase_q + 1'b1;
                        set_cnt_d = SET_W'(SETTLE - 1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort falls back to the last completed sweep's result.
        if (abort) begin
            state_d       = ST_IDLE;
            vld_d         = 1'b0;
            done_d        = 1'b0;
            best_phase_d  = shd_phase_q;
            best_margin_d = shd_margin_q;
            shd_phase_d   = shd_phase_q;
            shd_margin_d  = shd_margin_q;
            phase_d       = shd_phase_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            set_cnt_q     <= '0;
            smp_cnt_q     <= '0;
            min_hi_q      <= '1;
            max_lo_q      <= '0;
            seen_hi_q     <= 1'b0;
            seen_lo_q     <= 1'b0;
            phase_q       <= '0;
            rphase_q      <= '0;
            rmargin_q     <= '0;
            ropen_q       <= 1'b0;
            vld_q         <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            best_phase_q  <= '0;
            best_margin_q <= M_NONE;
            shd_phase_q   <= '0;
            shd_margin_q  <= M_NONE;
        end else begin
            state_q       <= state_d;
            set_cnt_q     <= set_cnt_d;
            smp_cnt_q     <= smp_cnt_d;
            min_hi_q      <= min_hi_d;
            max_lo_q      <= max_lo_d;
            seen_hi_q     <= seen_hi_d;
            seen_lo_q     <= seen_lo_d;
            phase_q       <= phase_d;
            rphase_q      <= rphase_d;
            rmargin_q     <= rmargin_d;
            ropen_q       <= ropen_d;
            vld_q         <= vld_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            best_phase_q  <= best_phase_d;
            best_margin_q <= best_margin_d;
            shd_phase_q   <= shd_phase_d;
            shd_margin_q  <= shd_margin_d;
        end
    end

    assign phase_code     = phase_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign best_phase     = best_phase_q;
    assign best_margin    = best_margin_q;
    assign res.res_valid  = vld_q;
    assign res.res_phase  = rphase_q;
    assign res.res_margin = rmargin_q;
    assign res.res_open   = ropen_q;
endmodule

// File: tb/tb_adc_phase_sweep.sv
// Directed bench for adc_phase_sweep with a PRBS-driven two-level ADC eye model.
// Latency: n/a. Backpressure: stalls res_ready at one phase.
module tb_adc_phase_sweep;
    import adc_cal_pkg::*;

    localparam int ADC_W = 6, PHASE_W = 5, N_PHASE = 20;
    localparam int SETTLE = 4, LOG2_NSAMP = 4, REF_LAT = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1, start = 1'b0, abort = 1'b0, prbs_bit = 1'b0;
    logic [ADC_W-1:0]   adc_data = '0;
    logic [PHASE_W-1:0] phase_code, best_phase;
    logic               busy, done;
    margin_t            best_margin;

    adc_phase_sweep_if #(.ADC_W(ADC_W), .PHASE_W(PHASE_W)) res_if ();

    adc_phase_sweep #(
        .ADC_W(ADC_W), .PHASE_W(PHASE_W), .N_PHASE(N_PHASE),
        .SETTLE(SETTLE), .LOG2_NSAMP(LOG2_NSAMP), .REF_LAT(REF_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .adc_data(adc_data), .prbs_bit(prbs_bit),
        .phase_code(phase_code), .busy(busy), .done(done),
        .res(res_if.master),
        .best_phase(best_phase), .best_margin(best_margin)
    );

    always #5 clk = ~clk;

    int          errs = 0, checks = 0;
    int          mode = 0;       // 0 ideal eye, 1 phase-dependent eye, 2 PRBS stuck at 1
    int          model_lat = 8;  // ADC model delay relative to the un-delayed PRBS
    logic [63:0] hist = '0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eye_margin(input int m, input int p);
        int d;
        d = (p > 7) ? p - 7 : 7 - p;
        if (m == 1) return 40 - 4 * d;
        if (m == 2) return -64;
        return 32;
    endfunction

    // Advance one clock, sample point is 1 time unit after the edge; drive next PRBS/ADC values.
    task automatic tick();
        int hi;
        @(posedge clk);
        #1;
        hist     = {hist[62:0], (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1))};
        prbs_bit = hist[0];
        hi       = (mode == 1) ? 16 + eye_margin(1, int'(phase_code)) : 48;
        adc_data = hist[model_lat] ? ADC_W'(hi) : ADC_W'(16);
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_phase_code"}, phase_code, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_res_valid"}, res_if.res_valid, 0);
        chk({pfx, "_res_phase"}, res_if.res_phase, 0);
        chk({pfx, "_res_margin"}, res_if.res_margin, 0);
        chk({pfx, "_res_open"}, res_if.res_open, 0);
        chk({pfx, "_best_phase"}, best_phase, 0);
        chk({pfx, "_best_margin"}, best_margin, -64);
    endtask

    // Accept results until done; m==3 means misaligned reference (only the open flag is predictable).
    task automatic collect(input int m, input int stall_at);
        int idx;
        bit got_done, stable;
        logic [PHASE_W-1:0] p0;
        logic signed [ADC_W:0] m0;
        logic o0;
        idx = 0;
        got_done = 0;
        for (int t = 0; t < 2000 && !got_done; t++) begin
            if (res_if.res_valid) begin
                if (int'(res_if.res_phase) == stall_at && res_if.res_ready) begin
                    res_if.res_ready = 1'b0;
                    p0 = res_if.res_phase; m0 = res_if.res_margin; o0 = res_if.res_open;
                    stable = 1;
                    repeat (50) begin
                        tick();
                        if (!(res_if.res_valid && res_if.res_phase == p0 && res_if.res_margin == m0 &&
                              res_if.res_open == o0 && phase_code == 5'd3)) stable = 0;
                    end
                    chk("bp_stable", stable, 1);
                    chk("bp_phase_code", phase_code, 3);
                    res_if.res_ready = 1'b1;
                end
                chk("res_phase", res_if.res_phase, idx);
                if (m != 3) begin
                    chk("res_margin", res_if.res_margin, eye_margin(m, idx));
                    chk("res_open", res_if.res_open, eye_margin(m, idx) > 0);
                end else begin
                    chk("res_open_misaligned", res_if.res_open, 0);
                end
                idx++;
            end
            if (done) got_done = 1;
            else tick();
        end
        chk("n_results", idx, N_PHASE);
        chk("done_seen", got_done, 1);
    endtask

    initial begin
        bit saw_done;
        res_if.res_ready = 1'b1;
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        repeat (10) tick();

        // Ideal eye with first-phase timing.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_phase", phase_code, 0);
        repeat (20) tick();
        chk("valid_edge20", res_if.res_valid, 0);
        tick();
        chk("valid_edge21", res_if.res_valid, 1);
        collect(0, -1);
        chk("ideal_best_phase", best_phase, 0);
        chk("ideal_best_margin", best_margin, 32);
        chk("ideal_phase_code", phase_code, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);

        // Reference misaligned by one cycle.
        model_lat = 9;
        repeat (12) tick();
        start = 1'b1; tick(); start = 1'b0;
        collect(3, -1);
        tick();
        model_lat = 8;

        // Single symbol class.
        mode = 2;
        repeat (12) tick();
        start = 1'b1; tick(); start = 1'b0;
        collect(2, -1);
        chk("single_best_phase", best_phase, 0);
        chk("single_best_margin", best_margin, -64);
        tick();

        // Phase-dependent eye with backpressure at phase 3.
        mode = 1;
        repeat (12) tick();
        start = 1'b1; tick(); start = 1'b0;
        collect(1, 3);
        chk("eye_best_phase", best_phase, 7);
        chk("eye_best_margin", best_margin, 40);
        chk("eye_done_phase_code", phase_code, 7);
        tick();
        chk("eye_idle_phase_code", phase_code, 7);

        // Abort during MEASURE of phase 4.
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 500 && phase_code != 5'd4; t++) tick();
        chk("reach_phase4", phase_code, 4);
        repeat (8) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", res_if.res_valid, 0);
        chk("abort_best_phase", best_phase, 7);
        chk("abort_best_margin", best_margin, 40);
        chk("abort_phase_code", phase_code, 7);
        saw_done = 0;
        repeat (5) begin
            tick();
            if (done) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);

        // Reset mid-sweep, then abort-vs-start priority and shadow reset.
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset("midrst");
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("shadow_rst_best_phase", best_phase, 0);
        chk("shadow_rst_best_margin", best_margin, -64);
        chk("shadow_rst_phase_code", phase_code, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
